// File: rtl/div_unit.sv
// div_unit: sequential signed divider (MIPS DIV), restoring algorithm, one quotient bit per clock.
//   lo = quotient (truncated toward zero), hi = remainder (carries the dividend's sign).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   div_control  start pulse, sampled only while idle
//   A, B         signed dividend / divisor
//   hi, lo       registered remainder / quotient, held until the next result
//   busy         high while a division is in flight
//   done         one-cycle pulse when hi/lo have just been updated
//   div_zero     one-cycle pulse with done on a trapped divide-by-zero
//
// Build option
//   DIV_ZERO_TRAP_EN  B==0 finishes after one cycle with div_zero set and hi/lo untouched.
//                     Without it div_zero is 0 and B==0 runs the full sequence, giving
//                     lo = all ones, hi = A.

module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out the top, quotient bits shift in below
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // Magnitudes; the most negative value maps onto itself, which is correct read as unsigned.
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  // Trial step: the extra top bit keeps the shifted partial remainder from overflowing.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d    = state_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (div_control) begin
          neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
          neg_rem_d = A[WIDTH-1];
          zero_d    = (B == '0);
          dvd_d     = abs_a;
          dvs_d     = abs_b;
          rem_d     = '0;
          count_d   = '0;
          busy_d    = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
          state_d   = (B == '0) ? StFix : StRun;
`else
          state_d   = StRun;
`endif
        end
      end

      StRun: begin
        // Result of a successful subtract is below the divisor, so WIDTH bits suffice.
        rem_d   = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], fits};
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = StFix;
        end
      end

      StFix: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
`ifdef DIV_ZERO_TRAP_EN
        if (zero_q) begin
          div_zero_d = 1'b1;
        end else begin
          lo_d = neg_quo_q ? -dvd_q : dvd_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end
`else
        // With a zero divisor the remainder collapses to |A|, so hi naturally equals A.
        lo_d = zero_q ? '1 : (neg_quo_q ? -dvd_q : dvd_q);
        hi_d = neg_rem_q ? -rem_q : rem_q;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed spec vectors, busy/done handshake, re-start while busy,
// mid-operation reset, back-to-back start on the done cycle, and random signed pairs
// against a reference model. Expected results go into a queue when an operation starts.

module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_control(div_control),
    .A          (A),
    .B          (B),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference signed division with the MIPS wrap case made explicit.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo);
    int sa;
    int sb_;
    sa  = a;
    sb_ = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      elo = 32'h8000_0000;
      ehi = 32'h0;
    end else begin
      elo = sa / sb_;
      ehi = sa % sb_;
    end
  endtask

  // Called at a negedge; drives the start so it is sampled by the next posedge (E0).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    A           = a;
    B           = b;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    div_control = 1'b0;
    A           = $urandom;   // only the latched operands may matter
    B           = $urandom;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  // n counts posedges since E0 at each negedge sample.
  task automatic wait_done(input int pulse_at, input bit chain);
    exp_t e;
    int   n;
    bit   seen;
    n    = -1;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (pulse_at > 0 && n == pulse_at) begin
        div_control = 1'b1;
        A           = 32'd9;
        B           = 32'd9;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        div_control = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      chk("done_timeout", {31'b0, done}, 32'd1);
      return;
    end
    chk("latency", 32'(n), 32'(e.lat));
    chk("lo", lo, e.lo);
    chk("hi", hi, e.hi);
    chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
    chk("busy_on_done", {31'b0, busy}, 32'd0);
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("div_zero_one_cycle", {31'b0, div_zero}, 32'd0);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      chk("lo_hold", lo, e.lo);
      chk("hi_hold", hi, e.hi);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo,
                    input logic edz, input int elat, input bit chain, input int pulse_at);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.dz  = edz;
    e.lat = elat;
    sb.push_back(e);
    start(a, b);
    wait_done(pulse_at, chain);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ehi;
    logic [31:0] elo;
    bit          saw_done;

    reset       = 1'b1;
    div_control = 1'b0;
    A           = '0;
    B           = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_div_zero", {31'b0, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0, 0);
    op(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33, 1'b0, 0);
    op(32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 33, 1'b0, 0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0, 0);
    op(32'h7FFF_FFFF, 32'd1, 32'd0, 32'h7FFF_FFFF, 1'b0, 33, 1'b0, 0);
    op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0, 33, 1'b0, 0);

    // Preset hi/lo to 5/6, then divide by zero.
    op(32'd47, 32'd7, 32'd5, 32'd6, 1'b0, 33, 1'b0, 0);
`ifdef DIV_ZERO_TRAP_EN
    op(32'd123, 32'd0, 32'd5, 32'd6, 1'b1, 1, 1'b0, 0);
    op(32'hFFFF_FFFB, 32'd0, 32'd5, 32'd6, 1'b1, 1, 1'b0, 0);
`else
    op(32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 0);
    op(32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 0);
`endif

    // Start pulse while busy must be ignored.
    op(32'd50, 32'd3, 32'd2, 32'd16, 1'b0, 33, 1'b0, 10);

    // Reset mid-operation aborts without a done pulse.
    start(32'd1000, 32'd10);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", {31'b0, saw_done}, 32'd0);
    op(32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 33, 1'b0, 0);

    // New start on the done cycle is accepted at the following edge.
    op(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1, 0);
    op(32'd77, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF1, 1'b0, 33, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) begin
        rb = $urandom_range(1, 50);
        if (i % 4 == 1) rb = -rb;
      end
      if (rb == 32'd0) rb = 32'd3;
      model(ra, rb, ehi, elo);
      op(ra, rb, ehi, elo, 1'b0, 33, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
